// File: rtl/intersection_controller_if.sv
// Purpose : bundles the command/config inputs and light/status outputs of the intersection controller.
// Latency : n/a (wiring only).
// Backpres: none; tick/run/cfg_we are single-cycle strobes or levels with no handshake.
// Ports   : tick, run, cfg_we, cfg_sel[1:0], cfg_time[CW-1:0] toward the controller;
//           light_state[7:0], phase[2:0], sec_left[CW-1:0] from it.
//           With PED_REQ_EN defined: ped_req toward the controller, ped_walk from it.
interface intersection_controller_if #(
    parameter int CW = 4
);
    logic          tick;
    logic          run;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [CW-1:0] cfg_time;
    logic [7:0]    light_state;
    logic [2:0]    phase;
    logic [CW-1:0] sec_left;
`ifdef PED_REQ_EN
    logic          ped_req;
    logic          ped_walk;

    modport master (output tick, run, cfg_we, cfg_sel, cfg_time, ped_req,
                    input  light_state, phase, sec_left, ped_walk);
    modport slave  (input  tick, run, cfg_we, cfg_sel, cfg_time, ped_req,
                    output light_state, phase, sec_left, ped_walk);
`else
    modport master (output tick, run, cfg_we, cfg_sel, cfg_time,
                    input  light_state, phase, sec_left);
    modport slave  (input  tick, run, cfg_we, cfg_sel, cfg_time,
                    output light_state, phase, sec_left);
`endif
endinterface

// File: rtl/intersection_controller.sv
// Purpose : sequences the NS (lights 0,2) and EW (lights 1,3) axes green->yellow->all-red, owns the green-time table.
// Latency : state/lights change on the clk edge of the qualifying tick; run changes act on the next edge.
// Backpres: none; every tick is consumed, cfg writes always land the following edge.
// Ports   : clk, rst (async, active high); bus = intersection_controller_if.slave.
// Option  : PED_REQ_EN adds a pedestrian walk phase after an all-red clearance.
// Phase encoding: 0 IDLE, 1 NS_G, 2 NS_Y, 3 NS_AR, 4 EW_G, 5 EW_Y, 6 EW_AR, 7 PED.
module intersection_controller #(
    parameter int CW          = 4,
    parameter int DEF_GREEN   = 10,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int PED_TIME    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    intersection_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0, NS_G = 3'd1, NS_Y = 3'd2, NS_AR = 3'd3,
        EW_G  = 3'd4, EW_Y = 3'd5, EW_AR = 3'd6, PED = 3'd7
    } state_t;

    localparam logic [CW-1:0] DEF_G_C = CW'(DEF_GREEN);
    localparam logic [CW-1:0] YEL_C   = CW'(YELLOW_TIME);
    localparam logic [CW-1:0] AR_C    = CW'(ALLRED_TIME);
    localparam logic [CW-1:0] PED_C   = CW'(PED_TIME);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] sec_cnt_q, sec_cnt_d;
    logic [CW-1:0] table_q [4];
    logic [CW-1:0] table_d [4];
    // Lights of the active axis that were granted green on entry; yellow reuses it
    // so a mid-green table write cannot make a light jump straight to yellow.
    logic [3:0]    mask_q, mask_d;
    logic [CW-1:0] g_ns, g_ew;
    logic          go_ns, go_ew, enter_ped;
    logic          ped_pend, ped_to_ew;
    logic [7:0]    light;

`ifdef PED_REQ_EN
    logic ped_pend_q, ped_pend_d, ped_to_ew_q, ped_to_ew_d;
    assign ped_pend = ped_pend_q;
    assign ped_to_ew = ped_to_ew_q;

    // A request arriving on the PED entry edge re-arms for the next clearance.
    always_comb begin
        ped_pend_d  = (ped_pend_q && !enter_ped) || bus.ped_req;
        ped_to_ew_d = enter_ped ? (state_q == NS_AR) : ped_to_ew_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend_q  <= 1'b0;
            ped_to_ew_q <= 1'b0;
        end else begin
            ped_pend_q  <= ped_pend_d;
            ped_to_ew_q <= ped_to_ew_d;
        end
    end

    assign bus.ped_walk = (state_q == PED);
`else
    assign ped_pend = 1'b0;
    assign ped_to_ew = 1'b0;
`endif

    always_comb begin
        g_ns      = (table_q[0] > table_q[2]) ? table_q[0] : table_q[2];
        g_ew      = (table_q[1] > table_q[3]) ? table_q[1] : table_q[3];
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        mask_d    = mask_q;
        go_ns     = 1'b0;
        go_ew     = 1'b0;
        enter_ped = 1'b0;
        table_d   = table_q;
        if (bus.cfg_we) table_d[bus.cfg_sel] = bus.cfg_time;

        if (!bus.run) begin
            state_d   = IDLE;
            sec_cnt_d = '0;
        end else if (state_q == IDLE) begin
            // Start with a full clearance so no light turns green straight from hold.
            state_d   = EW_AR;
            sec_cnt_d = AR_C;
        end else if (bus.tick) begin
            if (sec_cnt_q > ONE_C) begin
                sec_cnt_d = sec_cnt_q - ONE_C;
            end else begin
                unique case (state_q)
                    NS_G:    begin state_d = NS_Y;  sec_cnt_d = YEL_C; end
                    NS_Y:    begin state_d = NS_AR; sec_cnt_d = AR_C;  end
                    NS_AR:   if (ped_pend) enter_ped = 1'b1; else go_ew = 1'b1;
                    EW_G:    begin state_d = EW_Y;  sec_cnt_d = YEL_C; end
                    EW_Y:    begin state_d = EW_AR; sec_cnt_d = AR_C;  end
                    EW_AR:   if (ped_pend) enter_ped = 1'b1; else go_ns = 1'b1;
                    PED:     if (ped_to_ew) go_ew = 1'b1; else go_ns = 1'b1;
                    default: begin state_d = IDLE; sec_cnt_d = '0; end
                endcase
            end
        end

        if (enter_ped) begin
            state_d   = PED;
            sec_cnt_d = PED_C;
        end
        // Entering an axis reads the registered table, i.e. before any same-cycle write.
        // An axis with no green time is skipped straight to its own all-red.
        if (go_ns) begin
            if (g_ns != '0) begin
                state_d   = NS_G;
                sec_cnt_d = g_ns;
                mask_d    = {1'b0, table_q[2] != '0, 1'b0, table_q[0] != '0};
            end else begin
                state_d   = NS_AR;
                sec_cnt_d = AR_C;
            end
        end
        if (go_ew) begin
            if (g_ew != '0) begin
                state_d   = EW_G;
                sec_cnt_d = g_ew;
                mask_d    = {table_q[3] != '0, 1'b0, table_q[1] != '0, 1'b0};
            end else begin
                state_d   = EW_AR;
                sec_cnt_d = AR_C;
            end
        end
    end

    // Two bits per light: 00 red, 01 green, 10 yellow; only one axis is ever non-red.
    always_comb begin
        light = 8'h00;
        unique case (state_q)
            NS_G:    light = {3'b000, mask_q[2], 3'b000, mask_q[0]};
            NS_Y:    light = {2'b00, mask_q[2], 3'b000, mask_q[0], 1'b0};
            EW_G:    light = {1'b0, mask_q[3], 3'b000, mask_q[1], 2'b00};
            EW_Y:    light = {mask_q[3], 3'b000, mask_q[1], 3'b000};
            default: light = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sec_cnt_q <= '0;
            mask_q    <= '0;
            for (int i = 0; i < 4; i++) table_q[i] <= DEF_G_C;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
            mask_q    <= mask_d;
            table_q   <= table_d;
        end
    end

    assign bus.light_state = light;
    assign bus.phase       = state_q;
    assign bus.sec_left    = sec_cnt_q;
endmodule

// File: tb/tb_intersection_controller.sv
// Purpose : self-checking bench for intersection_controller: vector table, directed corner cases,
//           then randomized traffic against a segment-queue reference model.
// Latency : n/a.  Backpres: n/a.
module tb_intersection_controller;
    localparam int CW = 4;
    localparam int P_IDLE = 0, P_NSG = 1, P_NSY = 2, P_NSAR = 3;
    localparam int P_EWG = 4, P_EWY = 5, P_EWAR = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    intersection_controller_if #(.CW(CW)) bus ();

    intersection_controller #(
        .CW(CW), .DEF_GREEN(10), .YELLOW_TIME(3), .ALLRED_TIME(1), .PED_TIME(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the upcoming timeline as a queue of segments {phase, lights, seconds}.
    // When the head expires it is dropped; once an all-red ends, the next axis' segments
    // are appended from the table as it stands at that moment.
    typedef struct {int ph; int lt; int secs;} seg_t;
    seg_t mq[$];
    int   mtbl[4];

    task automatic push_axis(input bit ew);
        int a, b, g, lg, ly;
        a  = ew ? 1 : 0;
        b  = ew ? 3 : 2;
        g  = (mtbl[a] > mtbl[b]) ? mtbl[a] : mtbl[b];
        lg = 0;
        ly = 0;
        if (mtbl[a] != 0) begin lg += 1 << (2 * a); ly += 2 << (2 * a); end
        if (mtbl[b] != 0) begin lg += 1 << (2 * b); ly += 2 << (2 * b); end
        if (g > 0) begin
            mq.push_back('{ew ? P_EWG : P_NSG, lg, g});
            mq.push_back('{ew ? P_EWY : P_NSY, ly, 3});
        end
        mq.push_back('{ew ? P_EWAR : P_NSAR, 0, 1});
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mtbl[i] = 10;
        end else begin
            if (!bus.run) begin
                mq.delete();
            end else if (mq.size() == 0) begin
                mq.push_back('{P_EWAR, 0, 1});
            end else if (bus.tick) begin
                seg_t h;
                h = mq[0];
                if (h.secs > 1) begin
                    h.secs--;
                    mq[0] = h;
                end else begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) push_axis(h.ph == P_NSAR);
                end
            end
            if (bus.cfg_we) mtbl[bus.cfg_sel] = int'(bus.cfg_time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input int lt, input int ph, input int sec);
        chk({name, " light"}, 32'(bus.light_state), lt);
        chk({name, " phase"}, 32'(bus.phase), ph);
        chk({name, " sec"},   32'(bus.sec_left), sec);
    endtask

    // One clock with inputs held from the previous negedge; strobes clear afterwards.
    task automatic step(input bit t);
        bus.tick = t;
        @(posedge clk);
        @(negedge clk);
        bus.tick   = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic wr(input int sel, input int tm);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'(sel);
        bus.cfg_time = CW'(tm);
        step(1'b0);
    endtask

    typedef struct {int n; int lt; int ph; int sec;} vec_t;
    vec_t vt[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vt.push_back('{1,  'h11, P_NSG,  10});
        vt.push_back('{9,  'h11, P_NSG,  1});
        vt.push_back('{1,  'h22, P_NSY,  3});
        vt.push_back('{2,  'h22, P_NSY,  1});
        vt.push_back('{1,  'h00, P_NSAR, 1});
        vt.push_back('{1,  'h44, P_EWG,  10});
        vt.push_back('{9,  'h44, P_EWG,  1});
        vt.push_back('{1,  'h88, P_EWY,  3});
        vt.push_back('{3,  'h00, P_EWAR, 1});
        vt.push_back('{1,  'h11, P_NSG,  10});

        bus.tick = 1'b0; bus.run = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_sel = 2'd0; bus.cfg_time = '0;
        repeat (2) @(negedge clk);
        chk3("reset", 0, P_IDLE, 0);
        rst = 1'b0;
        step(1'b1);
        chk3("idle_tick", 0, P_IDLE, 0);

        // Default cycle from a run request
        bus.run = 1'b1;
        step(1'b0);
        chk3("run_up", 0, P_EWAR, 1);
        for (int i = 0; i < vt.size(); i++) begin
            repeat (vt[i].n) step(1'b1);
            chk3($sformatf("vec%0d", i), vt[i].lt, vt[i].ph, vt[i].sec);
        end

        // Drop run in the middle of NS yellow, then restart
        repeat (10) step(1'b1);
        step(1'b1);
        chk3("ns_y2", 'h22, P_NSY, 2);
        bus.run = 1'b0;
        step(1'b0);
        chk3("drop", 0, P_IDLE, 0);
        bus.run = 1'b1;
        step(1'b0);
        chk3("rerun", 0, P_EWAR, 1);
        step(1'b1);
        chk3("rerun_g", 'h11, P_NSG, 10);

        // Unequal NS greens: axis time is the larger entry
        bus.run = 1'b0; step(1'b0);
        wr(0, 6); wr(2, 2);
        bus.run = 1'b1; step(1'b0); step(1'b1);
        chk3("t2_g", 'h11, P_NSG, 6);
        repeat (5) step(1'b1);
        chk3("t2_g1", 'h11, P_NSG, 1);
        step(1'b1);
        chk3("t2_y", 'h22, P_NSY, 3);

        // EW axis empty, light 2 off: only light 0 runs, EW skipped to its all-red
        bus.run = 1'b0; step(1'b0);
        wr(1, 0); wr(3, 0); wr(2, 0);
        bus.run = 1'b1; step(1'b0); step(1'b1);
        chk3("t3_g", 'h01, P_NSG, 6);
        repeat (6) step(1'b1);
        chk3("t3_y", 'h02, P_NSY, 3);
        repeat (3) step(1'b1);
        chk3("t3_ar", 0, P_NSAR, 1);
        step(1'b1);
        chk3("t3_skip", 0, P_EWAR, 1);
        step(1'b1);
        chk3("t3_back", 'h01, P_NSG, 6);

        // All entries zero: all-red ping-pong
        bus.run = 1'b0; step(1'b0);
        wr(0, 0);
        bus.run = 1'b1; step(1'b0);
        chk3("t4_start", 0, P_EWAR, 1);
        step(1'b1);
        chk3("t4_a", 0, P_NSAR, 1);
        step(1'b1);
        chk3("t4_b", 0, P_EWAR, 1);
        step(1'b1);
        chk3("t4_c", 0, P_NSAR, 1);

        // Write in the same cycle as the entering tick: entry uses the old value
        bus.run = 1'b0; step(1'b0);
        wr(0, 4); wr(1, 5); wr(2, 4); wr(3, 5);
        bus.run = 1'b1; step(1'b0);
        bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_time = CW'(9);
        step(1'b1);
        chk3("wr_tick", 'h11, P_NSG, 4);
        repeat (17) step(1'b1);
        chk3("wr_next", 'h11, P_NSG, 9);

        // Asynchronous reset mid-cycle restores default table
        step(1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk3("arst", 0, P_IDLE, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0);
        chk3("arst_ar", 0, P_EWAR, 1);
        step(1'b1);
        chk3("arst_tbl", 'h11, P_NSG, 10);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            bus.tick     = ($urandom_range(0, 2) == 0);
            bus.run      = ($urandom_range(0, 149) != 0);
            bus.cfg_we   = ($urandom_range(0, 24) == 0);
            bus.cfg_sel  = 2'($urandom_range(0, 3));
            bus.cfg_time = ($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom_range(1, 6));
            @(posedge clk);
            @(negedge clk);
            if (mq.size() == 0) chk3($sformatf("rand%0d", c), 0, P_IDLE, 0);
            else                chk3($sformatf("rand%0d", c), mq[0].lt, mq[0].ph, mq[0].secs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
